// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: FSM encodings
// and the legal read-latency values.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned RD_LAT_COMB = 1;  // RAM without output register
  localparam int unsigned RD_LAT_REG  = 2;  // RAM with output register

  function automatic bit rd_latency_legal(input int unsigned lat);
    return (lat == RD_LAT_COMB) || (lat == RD_LAT_REG);
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with lock support sharing one synchronous RAM port
// between two requesters; read responses are routed back after RD_LATENCY.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // An illegal latency falls back to the unregistered-RAM timing.
  localparam int unsigned LAT = rd_latency_legal(RD_LATENCY) ? RD_LATENCY : RD_LAT_COMB;

  arb_state_t     r_state;
  logic           r_last;      // 1 = requester 1 was granted last
  logic [LAT-1:0] r_pipe_v;
  logic [LAT-1:0] r_pipe_id;

  logic           w_rdy0;
  logic           w_rdy1;
  logic           w_hs;
  logic           w_gnt1;
  logic           w_gnt_we;
  logic           w_gnt_lock;
  logic           w_rd_issue;
  logic           w_tap_v;

  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (req0_valid && req1_valid) begin
            w_rdy0 = r_last;
            w_rdy1 = !r_last;
          end else begin
            w_rdy0 = req0_valid;
            w_rdy1 = req1_valid;
          end
        end
        ST_LOCK0: w_rdy0 = req0_valid;
        ST_LOCK1: w_rdy1 = req1_valid;
        default: ;
      endcase
    end
  end

  assign w_hs       = w_rdy0 | w_rdy1;
  assign w_gnt1     = w_rdy1;
  assign w_gnt_we   = w_gnt1 ? req1_we   : req0_we;
  assign w_gnt_lock = w_gnt1 ? req1_lock : req0_lock;
  assign w_rd_issue = w_hs & !w_gnt_we;

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign ram_we     = w_hs & w_gnt_we;
  assign ram_addr   = w_gnt1 ? req1_addr  : req0_addr;
  assign ram_din    = w_gnt1 ? req1_wdata : req0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_pipe_v  <= '0;
      r_pipe_id <= '0;
    end else begin
      if (w_hs) begin
        r_last  <= w_gnt1;
        r_state <= w_gnt_lock ? (w_gnt1 ? ST_LOCK1 : ST_LOCK0) : ST_IDLE;
      end
      // Shift by one stage; the concatenation's top bit falls off the end.
      r_pipe_v  <= LAT'({r_pipe_v,  w_rd_issue});
      r_pipe_id <= LAT'({r_pipe_id, w_gnt1});
    end
  end

  assign w_tap_v    = r_pipe_v[LAT-1] & !reset;
  assign rsp0_valid = w_tap_v & !r_pipe_id[LAT-1];
  assign rsp1_valid = w_tap_v &  r_pipe_id[LAT-1];
  assign rsp0_rdata = rsp0_valid ? ram_dout : '0;
  assign rsp1_rdata = rsp1_valid ? ram_dout : '0;

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, RAM address width.
REQ-003 SHALL have parameter RD_LATENCY, default 1, RAM read latency in cycles; legal values are 1 (no output register) and 2 (output register).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports reqN_valid, input, 1, requester N (N=0,1) command valid.
REQ-007 SHALL have ports reqN_ready, output, 1, command accepted this cycle.
REQ-008 SHALL have ports reqN_we, input, 1, 1=write, 0=read.
REQ-009 SHALL have ports reqN_lock, input, 1, hold grant after this command.
REQ-010 SHALL have ports reqN_addr, input, ADDR_WIDTH, command address.
REQ-011 SHALL have ports reqN_wdata, input, DATA_WIDTH, write data.
REQ-012 SHALL have ports rspN_valid, output, 1, read data valid strobe.
REQ-013 SHALL have ports rspN_rdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port ram_we, output, 1, to RAM port we.
REQ-015 SHALL have port ram_addr, output, ADDR_WIDTH, to RAM port addr.
REQ-016 SHALL have port ram_din, output, DATA_WIDTH, to RAM port din.
REQ-017 SHALL have port ram_dout, input, DATA_WIDTH, from RAM port dout.

Function
REQ-018 SHALL accept at most one command per cycle; handshake = reqN_valid & reqN_ready; reqN_ready is combinational from the valids, FSM state and the round-robin pointer.
REQ-019 SHALL drive ram_addr/ram_din from the granted requester, and ram_we = granted reqN_we & handshake; with no handshake, ram_we=0 and addr/din are don't-care.
REQ-020 SHALL arbitrate round-robin in state IDLE: a sole valid requester wins; if both are valid, the requester not granted last wins; pointer updates only on handshake.
REQ-021 SHALL implement FSM states IDLE, LOCK0, LOCK1; a handshake with lock=1 from N moves to LOCKN; in LOCKN only N may be granted; a handshake from N with lock=0 returns to IDLE.
REQ-022 SHALL in LOCKN hold reqM_ready=0 for M≠N regardless of reqM_valid, with no timeout.
REQ-023 SHALL assert rspN_valid for exactly one cycle, exactly RD_LATENCY cycles after an accepted read by N, with rspN_rdata = ram_dout in that cycle.
REQ-024 SHALL track in-flight reads with a RD_LATENCY-deep shift register of {valid, requester id}, permitting back-to-back reads at one per cycle.
REQ-025 SHALL never produce a response for writes, and SHALL hold rspN_rdata at 0 when rspN_valid=0.
REQ-026 SHALL keep read-after-write ordering: a read accepted the cycle after a write to the same address returns the new data.

Reset
REQ-027 SHALL on reset force FSM to IDLE, pointer to "last granted = 1" (requester 0 wins first tie), tracking pipeline cleared, all ready/rsp_valid/ram_we outputs 0.
REQ-028 SHALL discard reads in flight when reset is asserted mid-operation; no rsp_valid after reset deasserts for pre-reset commands.

Structure
REQ-029 SHALL place FSM state encodings and RD_LATENCY legal values in shared package ram_arb_pkg.
REQ-030 SHALL be one module with no sub-modules; the true dual-port RAM is instantiated by the parent.

Verification
REQ-031 SHALL verify: reset, then req0 write 0x012<-0xA5, req0 read 0x012, RD_LATENCY=1 -> rsp0_valid one cycle after read handshake, rdata 0xA5.
REQ-032 SHALL verify: both valid continuously, reads to 0x001 (req0) and 0x002 (req1) -> grants alternate 0,1,0,1, and each rsp goes to the correct requester.
REQ-033 SHALL verify: req0 lock=1 write, then req1 valid for 5 cycles -> req1_ready=0 until req0 issues a lock=0 command, then req1 is granted next cycle.
REQ-034 SHALL verify: RD_LATENCY=2, four back-to-back reads -> four rsp_valid pulses starting 2 cycles after the first handshake, data in order.
REQ-035 SHALL verify: reset asserted one cycle after a read handshake -> no rsp_valid after reset, and FSM is IDLE.
